// File: rtl/pcpi_result_serializer.sv
// pcpi_result_serializer: buffers PCPI write-back results in a FIFO and returns them
// to the host one nibble at a time over a four-phase nib_valid/host_ack handshake.
module pcpi_result_serializer #(
    parameter int DATA_W = 32,
    parameter int NIB_W  = 4,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pcpi_ready,
    input  logic              pcpi_wr,
    input  logic [DATA_W-1:0] pcpi_rd,
    input  logic              host_ack,
    output logic [NIB_W-1:0]  nib_out,
    output logic              nib_valid,
    output logic              nib_last,
    output logic              fifo_full,
    output logic              busy,
    output logic              overflow
);
    localparam int NIBS = DATA_W / NIB_W;
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = $clog2(NIBS);
    localparam int OW   = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] LAST = CW'(NIBS - 1);

    typedef enum logic [1:0] {IDLE, PRESENT, WAIT_LOW} state_t;

    state_t            state, state_nx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [OW-1:0]     occ;
    logic [DATA_W-1:0] shift;
    logic [CW-1:0]     count;
    logic              ack_m, ack_s;
    logic              empty, push_req, push, pop, advance;

    assign empty     = occ == '0;
    assign fifo_full = occ == OW'(DEPTH);
    assign pop       = state == IDLE && !empty;
    assign push_req  = pcpi_ready && pcpi_wr;
    // a pop in the same cycle frees a slot, so a full FIFO still accepts
    assign push      = push_req && (!fifo_full || pop);
    assign advance   = state == WAIT_LOW && !ack_s && count != LAST;
    assign busy      = state != IDLE || !empty;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (!empty) state_nx = PRESENT;
            PRESENT:  if (ack_s) state_nx = WAIT_LOW;
            WAIT_LOW: if (!ack_s) state_nx = count == LAST ? IDLE : PRESENT;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ack_m     <= 1'b0;
            ack_s     <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            shift     <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            nib_out   <= '0;
            nib_valid <= 1'b0;
            nib_last  <= 1'b0;
        end else begin
            state <= state_nx;
            {ack_s, ack_m} <= {ack_m, host_ack};
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            occ <= occ + OW'(push) - OW'(pop);
            if (push_req && fifo_full && !pop) overflow <= 1'b1;
            if (pop) begin
                shift <= mem[rd_ptr];
                count <= '0;
            end else if (advance) begin
                shift <= shift >> NIB_W;
                count <= count + 1'b1;
            end
            // registered presentation; nib_out holds through WAIT_LOW
            nib_valid <= state == PRESENT;
            nib_last  <= state == PRESENT && count == LAST;
            if (state == PRESENT) nib_out <= shift[NIB_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= pcpi_rd;
    end
endmodule
